// File: rtl/rv_tb_pkg.sv
// rtl/rv_tb_pkg.sv - shared state encoding and error codes for the store check monitor
package rv_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_BAD_ADDR = 2'd2;
  localparam logic [1:0] ERR_ORDER    = 2'd3;

  // Slot index width; a single slot still needs one index bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/store_check_monitor_if.sv
// rtl/store_check_monitor_if.sv - control, table-load, store-watch and result bundle
interface store_check_monitor_if #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 4
);
  logic             start;
  logic             exp_we;
  logic [IDX_W-1:0] exp_idx;
  logic [XLEN-1:0]  exp_data;
  logic             memwrite;
  logic [XLEN-1:0]  dataadr;
  logic [XLEN-1:0]  writedata;
  logic [IDX_W:0]   pass_cnt;
  logic [7:0]       fail_cnt;
  logic             done;
  logic             pass;
  logic             err_valid;
  logic [1:0]       err_code;
  logic [XLEN-1:0]  err_addr;
  logic [XLEN-1:0]  err_data;

  modport master (
    output start, exp_we, exp_idx, exp_data, memwrite, dataadr, writedata,
    input  pass_cnt, fail_cnt, done, pass, err_valid, err_code, err_addr, err_data
  );

  modport slave (
    input  start, exp_we, exp_idx, exp_data, memwrite, dataadr, writedata,
    output pass_cnt, fail_cnt, done, pass, err_valid, err_code, err_addr, err_data
  );
endinterface

// File: rtl/store_slot_decode.sv
// rtl/store_slot_decode.sv - maps a store byte address onto an expected-table slot
module store_slot_decode #(
  parameter int XLEN       = 32,
  parameter int NUM_CHECKS = 9,
  parameter int BASE_ADDR  = 200,
  parameter int STRIDE     = 4,
  parameter int IDX_W      = 4
) (
  input  logic [XLEN-1:0]  dataadr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  localparam int              SHIFT = $clog2(STRIDE);
  localparam logic [XLEN-1:0] BASE  = XLEN'(BASE_ADDR);
  localparam logic [XLEN-1:0] MASK  = XLEN'(STRIDE - 1);
  localparam logic [XLEN-1:0] LIMIT = XLEN'(NUM_CHECKS);

  logic [XLEN-1:0] off;
  logic [XLEN-1:0] slot;

  // STRIDE is a power of two, so the slot number is a shift and the remainder a mask.
  assign off  = dataadr - BASE;
  assign slot = off >> SHIFT;
  assign hit  = (dataadr >= BASE) && ((off & MASK) == '0) && (slot < LIMIT);
  assign idx  = slot[IDX_W-1:0];

endmodule

// File: rtl/store_check_monitor.sv
// rtl/store_check_monitor.sv - scores core stores against a loadable table of expected words
module store_check_monitor
  import rv_tb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_CHECKS = 9,
  parameter int BASE_ADDR  = 200,
  parameter int STRIDE     = 4,
  parameter int ORDERED    = 0,
  parameter int TIMEOUT    = 30
) (
  input logic                 clk,
  input logic                 rst_n,
  store_check_monitor_if.slave bus
);

  localparam int             IDX_W    = idx_width(NUM_CHECKS);
  localparam int             TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W:0] NUM_CNT  = (IDX_W + 1)'(NUM_CHECKS);

  state_t                state_q, state_d;
  logic [XLEN-1:0]       exp_tbl [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]      ptr_q;
  logic [TMR_W-1:0]      timer_q;
  logic [IDX_W:0]        pass_cnt_q;
  logic [7:0]            fail_cnt_q;
  logic                  err_valid_q;
  logic [1:0]            err_code_q;
  logic [XLEN-1:0]       err_addr_q;
  logic [XLEN-1:0]       err_data_q;

  logic                  slot_hit;
  logic [IDX_W-1:0]      slot_idx;
  logic                  not_run;
  logic                  do_start;
  logic                  ev_err;
  logic [1:0]            ev_code;
  logic                  ev_good;
  logic                  ev_match;

  store_slot_decode #(
    .XLEN       (XLEN),
    .NUM_CHECKS (NUM_CHECKS),
    .BASE_ADDR  (BASE_ADDR),
    .STRIDE     (STRIDE),
    .IDX_W      (IDX_W)
  ) u_decode (
    .dataadr (bus.dataadr),
    .hit     (slot_hit),
    .idx     (slot_idx)
  );

  assign not_run  = (state_q != ST_RUN);
  assign do_start = bus.start && not_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scoring uses the post-store mask, so a last-slot store on the timeout edge still counts.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ev_err   = 1'b0;
    ev_code  = ERR_NONE;
    ev_good  = 1'b0;
    ev_match = 1'b0;
    if (state_q == ST_RUN && bus.memwrite) begin
      if (!slot_hit) begin
        ev_err  = 1'b1;
        ev_code = ERR_BAD_ADDR;
      end else if (mask_q[slot_idx] || (ORDERED != 0 && slot_idx != ptr_q)) begin
        ev_err  = 1'b1;
        ev_code = ERR_ORDER;
      end else begin
        ev_good          = 1'b1;
        mask_d[slot_idx] = 1'b1;
        if (bus.writedata === exp_tbl[slot_idx]) begin
          ev_match = 1'b1;
        end else begin
          ev_err  = 1'b1;
          ev_code = ERR_MISMATCH;
        end
      end
    end
    case (state_q)
      ST_IDLE, ST_DONE: if (bus.start) state_d = ST_RUN;
      ST_RUN:           if ((&mask_d) || timer_q == TMR_LAST) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHECKS; i++) exp_tbl[i] <= '0;
      mask_q      <= '0;
      ptr_q       <= '0;
      timer_q     <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_addr_q  <= '0;
      err_data_q  <= '0;
    end else begin
      if (not_run && bus.exp_we && (32'(bus.exp_idx) < NUM_CHECKS)) begin
        exp_tbl[bus.exp_idx] <= bus.exp_data;
      end
      if (do_start) begin
        mask_q      <= '0;
        ptr_q       <= '0;
        timer_q     <= '0;
        pass_cnt_q  <= '0;
        fail_cnt_q  <= '0;
        err_valid_q <= 1'b0;
        err_code_q  <= ERR_NONE;
        err_addr_q  <= '0;
        err_data_q  <= '0;
      end else if (state_q == ST_RUN) begin
        mask_q <= mask_d;
        if (timer_q != TMR_LAST) timer_q <= timer_q + 1'b1;
        if (ev_good) ptr_q <= ptr_q + 1'b1;
        if (ev_match) pass_cnt_q <= pass_cnt_q + 1'b1;
        if (ev_err) begin
          if (fail_cnt_q != 8'hFF) fail_cnt_q <= fail_cnt_q + 8'd1;
          if (!err_valid_q) begin
            err_valid_q <= 1'b1;
            err_code_q  <= ev_code;
            err_addr_q  <= bus.dataadr;
            err_data_q  <= bus.writedata;
          end
        end
      end
    end
  end

  assign bus.pass_cnt  = pass_cnt_q;
  assign bus.fail_cnt  = fail_cnt_q;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = (state_q == ST_DONE) && (fail_cnt_q == 8'd0) && (pass_cnt_q == NUM_CNT);
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.err_data  = err_data_q;

endmodule

// File: tb/tb_store_check_monitor.sv
// tb/tb_store_check_monitor.sv - directed bench for an unordered and an ordered monitor instance
module tb_store_check_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  logic [31:0] tbl [9] = '{32'd300, 32'd1, 32'd1, 32'd96, 32'd244,
                           32'hFFFFFF9B, 32'd1600, 32'd6, 32'hFFFFFFF9};

  always #5 clk = ~clk;

  store_check_monitor_if #(.XLEN(32), .IDX_W(4)) if_u ();
  store_check_monitor_if #(.XLEN(32), .IDX_W(4)) if_o ();

  store_check_monitor #(.ORDERED(0), .TIMEOUT(30)) dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_u.slave)
  );

  store_check_monitor #(.ORDERED(1), .TIMEOUT(30)) dut_o (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_o.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drv_idle();
    if_u.start = 0; if_u.exp_we = 0; if_u.exp_idx = 0; if_u.exp_data = 0;
    if_u.memwrite = 0; if_u.dataadr = 0; if_u.writedata = 0;
    if_o.start = 0; if_o.exp_we = 0; if_o.exp_idx = 0; if_o.exp_data = 0;
    if_o.memwrite = 0; if_o.dataadr = 0; if_o.writedata = 0;
  endtask

  task automatic do_start();
    if_u.start = 1; if_o.start = 1;
    @(negedge clk);
    if_u.start = 0; if_o.start = 0;
  endtask

  task automatic load(input logic [3:0] idx, input logic [31:0] d);
    if_u.exp_we = 1; if_u.exp_idx = idx; if_u.exp_data = d;
    if_o.exp_we = 1; if_o.exp_idx = idx; if_o.exp_data = d;
    @(negedge clk);
    if_u.exp_we = 0; if_o.exp_we = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    if_u.memwrite = 1; if_u.dataadr = a; if_u.writedata = d;
    if_o.memwrite = 1; if_o.dataadr = a; if_o.writedata = d;
    @(negedge clk);
    if_u.memwrite = 0; if_o.memwrite = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && !(if_u.done && if_o.done); i++) @(negedge clk);
    check_eq("wait_done", {30'd0, if_u.done, if_o.done}, 32'd3);
  endtask

  initial begin
    drv_idle();
    #2;
    check_eq("rst_pass_cnt", 32'(if_u.pass_cnt), 0);
    check_eq("rst_fail_cnt", 32'(if_u.fail_cnt), 0);
    check_eq("rst_done", 32'(if_u.done), 0);
    check_eq("rst_err_valid", 32'(if_u.err_valid), 0);
    check_eq("rst_err_addr", if_u.err_addr, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 9; i++) load(4'(i), tbl[i]);

    // 1: all nine correct, in order
    do_start();
    for (int i = 0; i < 9; i++) store(32'(200 + 4 * i), tbl[i]);
    check_eq("t1_pass_cnt", 32'(if_u.pass_cnt), 9);
    check_eq("t1_fail_cnt", 32'(if_u.fail_cnt), 0);
    check_eq("t1_done", 32'(if_u.done), 1);
    check_eq("t1_pass", 32'(if_u.pass), 1);
    check_eq("t1_pass_ord", 32'(if_o.pass), 1);

    // 2: slot 0 data off by one
    do_start();
    store(32'd200, 32'd301);
    for (int i = 1; i < 9; i++) store(32'(200 + 4 * i), tbl[i]);
    check_eq("t2_err_code", 32'(if_u.err_code), 1);
    check_eq("t2_err_addr", if_u.err_addr, 200);
    check_eq("t2_err_data", if_u.err_data, 301);
    check_eq("t2_pass_cnt", 32'(if_u.pass_cnt), 8);
    check_eq("t2_pass", 32'(if_u.pass), 0);
    check_eq("t2_done", 32'(if_u.done), 1);

    // 3: bad addresses; first error kept; table write during RUN ignored
    do_start();
    store(32'd240, 32'hDEAD);
    store(32'd202, 32'h1);
    check_eq("t3_fail_cnt2", 32'(if_u.fail_cnt), 2);
    check_eq("t3_err_code", 32'(if_u.err_code), 2);
    check_eq("t3_err_addr", if_u.err_addr, 240);
    check_eq("t3_err_data", if_u.err_data, 32'hDEAD);
    store(32'd196, 32'h2);
    load(4'd0, 32'd5);
    for (int i = 0; i < 9; i++) store(32'(200 + 4 * i), tbl[i]);
    check_eq("t3_fail_cnt3", 32'(if_u.fail_cnt), 3);
    check_eq("t3_pass_cnt", 32'(if_u.pass_cnt), 9);
    check_eq("t3_pass", 32'(if_u.pass), 0);

    // duplicate store on slot 0
    do_start();
    store(32'd200, tbl[0]);
    store(32'd200, tbl[0]);
    check_eq("dup_err_code", 32'(if_u.err_code), 3);
    check_eq("dup_fail_cnt", 32'(if_u.fail_cnt), 1);
    check_eq("dup_pass_cnt", 32'(if_u.pass_cnt), 1);
    for (int i = 1; i < 9; i++) store(32'(200 + 4 * i), tbl[i]);
    check_eq("dup_done", 32'(if_u.done), 1);
    check_eq("dup_pass_cnt9", 32'(if_u.pass_cnt), 9);
    check_eq("dup_ord_fail", 32'(if_o.fail_cnt), 1);

    // 4: slot 1 before slot 0
    do_start();
    store(32'd204, tbl[1]);
    store(32'd200, tbl[0]);
    for (int i = 2; i < 9; i++) store(32'(200 + 4 * i), tbl[i]);
    check_eq("t4_unord_pass", 32'(if_u.pass), 1);
    check_eq("t4_ord_code", 32'(if_o.err_code), 3);
    check_eq("t4_ord_addr", if_o.err_addr, 204);
    check_eq("t4_ord_pass_cnt", 32'(if_o.pass_cnt), 1);
    check_eq("t4_ord_fail_cnt", 32'(if_o.fail_cnt), 8);
    check_eq("t4_ord_done", 32'(if_o.done), 0);
    wait_done();

    // 5: timeout after 30 RUN cycles with only five stores
    do_start();
    for (int i = 0; i < 5; i++) store(32'(200 + 4 * i), tbl[i]);
    idle(24);
    check_eq("t5_not_done29", 32'(if_u.done), 0);
    idle(1);
    check_eq("t5_done30", 32'(if_u.done), 1);
    check_eq("t5_pass_cnt", 32'(if_u.pass_cnt), 5);
    check_eq("t5_pass", 32'(if_u.pass), 0);

    // 5b: last store on the timeout edge
    do_start();
    for (int i = 0; i < 8; i++) store(32'(200 + 4 * i), tbl[i]);
    idle(21);
    check_eq("t5b_not_done", 32'(if_u.done), 0);
    store(32'd232, tbl[8]);
    check_eq("t5b_done", 32'(if_u.done), 1);
    check_eq("t5b_pass", 32'(if_u.pass), 1);
    check_eq("t5b_pass_ord", 32'(if_o.pass), 1);

    // 6: reset mid-RUN
    do_start();
    for (int i = 0; i < 4; i++) store(32'(200 + 4 * i), tbl[i]);
    #2 rst_n = 0;
    #1;
    check_eq("t6_pass_cnt", 32'(if_u.pass_cnt), 0);
    check_eq("t6_done", 32'(if_u.done), 0);
    check_eq("t6_err_valid", 32'(if_u.err_valid), 0);
    @(negedge clk);
    rst_n = 1;
    store(32'd200, 32'd300);
    check_eq("t6_idle_ignore", 32'(if_u.pass_cnt), 0);
    check_eq("t6_idle_done", 32'(if_u.done), 0);
    do_start();
    store(32'd200, 32'd0);
    check_eq("t6_tbl_cleared", 32'(if_u.pass_cnt), 1);
    check_eq("t6_tbl_fail", 32'(if_u.fail_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
